// File: rtl/fetch_pkg.sv
// Fetch unit shared definitions.
// Encodings, fixed addresses and the fetch FSM state type.
package fetch_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] ISR_VEC   = 16'h0002;

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_DRAIN,
        S_HALTED
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline latch.
// Bubble beats load; with neither asserted the latch holds.
module ifid_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bubble,
    input  logic        load,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc2_in,
    output logic [15:0] instr,
    output logic [15:0] pc2,
    output logic        valid
);

    // Latch update: a bubble keeps pc2 so downstream sees a stable value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr <= NOP_INSTR;
            pc2   <= RESET_PC;
            valid <= 1'b0;
        end else if (bubble) begin
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc2   <= pc2_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: PC, exception PC, memory handshake FSM.
// Feeds the IF/ID latch held in ifid_reg.
module fetch
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    input  logic        stall_id,
    input  logic        flush,
    input  logic [15:0] redirect_pc,
    input  logic        halt_id,
    input  logic        siic_id,
    input  logic        rti_id,
    output logic [15:0] instr_id,
    output logic [15:0] pc2_id,
    output logic        valid_id,
    output logic [15:0] epc
);

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  epc_d;
    logic [15:0]  pc_inc;
    logic         drain_halt_q, drain_halt_d;
    logic         busy;
    logic         bubble;
    logic         load;

    assign pc_inc    = pc_q + 16'd2;
    assign imem_addr = pc_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_WAIT);

    // State, PC, EPC and drain-destination registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_RUN;
            pc_q         <= RESET_PC;
            epc          <= RESET_PC;
            drain_halt_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc          <= epc_d;
            drain_halt_q <= drain_halt_d;
        end
    end

    // Next state: flush > halt > siic/rti > stall > normal fetch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epc_d        = epc;
        drain_halt_d = drain_halt_q;
        bubble       = 1'b0;
        load         = 1'b0;
        imem_rd      = busy;
        if (state_q == S_DRAIN) begin
            // Late completion is dropped; a new flush only moves PC.
            if (flush) begin
                pc_d = redirect_pc;
            end
            if (imem_done) begin
                state_d = drain_halt_q ? S_HALTED : S_RUN;
            end
        end else if (busy) begin
            if (flush) begin
                pc_d         = redirect_pc;
                bubble       = 1'b1;
                drain_halt_d = 1'b0;
                if ((state_q == S_WAIT) && !imem_done) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end else if (halt_id && !stall_id) begin
                bubble       = 1'b1;
                drain_halt_d = 1'b1;
                state_d      = imem_done ? S_HALTED : S_DRAIN;
            end else if ((siic_id || rti_id) && !stall_id) begin
                bubble       = 1'b1;
                drain_halt_d = 1'b0;
                if (siic_id) begin
                    epc_d = pc2_id;
                    pc_d  = ISR_VEC;
                end else begin
                    pc_d  = epc;
                end
                state_d = imem_done ? S_RUN : S_DRAIN;
            end else if (stall_id) begin
                // Any completion now is dropped; same PC is re-fetched.
                state_d = imem_done ? S_RUN : S_WAIT;
            end else if (imem_done) begin
                load    = 1'b1;
                pc_d    = pc_inc;
                state_d = S_RUN;
            end else begin
                bubble  = 1'b1;
                state_d = S_WAIT;
            end
        end
    end

    ifid_reg u_ifid (
        .clk      (clk),
        .rst      (rst),
        .bubble   (bubble),
        .load     (load),
        .instr_in (imem_data),
        .pc2_in   (pc_inc),
        .instr    (instr_id),
        .pc2      (pc2_id),
        .valid    (valid_id)
    );

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch unit.
// Memory returns addr ^ 16'hC3C3 as the instruction word.
module tb_fetch;

    localparam logic [15:0] NOP = 16'h0800;
    localparam logic [5:0] D = 6'b100000;
    localparam logic [5:0] S = 6'b010000;
    localparam logic [5:0] F = 6'b001000;
    localparam logic [5:0] H = 6'b000100;
    localparam logic [5:0] I = 6'b000010;
    localparam logic [5:0] R = 6'b000001;

    typedef struct {
        logic [5:0]  ctl;
        logic [15:0] rpc;
        logic [15:0] addr;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        valid;
        logic        rd;
        logic [15:0] epc;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_done;
    logic        stall_id;
    logic        flush;
    logic [15:0] redirect_pc;
    logic        halt_id;
    logic        siic_id;
    logic        rti_id;
    logic [15:0] instr_id;
    logic [15:0] pc2_id;
    logic        valid_id;
    logic [15:0] epc;

    int   vectors;
    int   miscompares;
    vec_t sb[$];

    function automatic logic [15:0] m(input logic [15:0] a);
        return a ^ 16'hC3C3;
    endfunction

    function automatic vec_t mk(input logic [5:0] c, input logic [15:0] r,
                                input logic [15:0] a, input logic [15:0] i,
                                input logic [15:0] p, input logic v,
                                input logic rd, input logic [15:0] e);
        vec_t x;
        x.ctl = c; x.rpc = r; x.addr = a; x.instr = i;
        x.pc2 = p; x.valid = v; x.rd = rd; x.epc = e;
        return x;
    endfunction

    assign imem_data = m(imem_addr);

    fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .imem_data   (imem_data),
        .imem_done   (imem_done),
        .stall_id    (stall_id),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .halt_id     (halt_id),
        .siic_id     (siic_id),
        .rti_id      (rti_id),
        .instr_id    (instr_id),
        .pc2_id      (pc2_id),
        .valid_id    (valid_id),
        .epc         (epc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic [5:0] c, input logic [15:0] r);
        {imem_done, stall_id, flush, halt_id, siic_id, rti_id} = c;
        redirect_pc = r;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        drive(6'b0, 16'h0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(D, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({imem_addr, instr_id, pc2_id, valid_id, epc, imem_rd} !==
            {16'h0, NOP, 16'h0, 1'b0, 16'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_hold: addr=%h instr=%h pc2=%h v=%b epc=%h rd=%b",
                     imem_addr, instr_id, pc2_id, valid_id, epc, imem_rd);
        end
        rst = 1'b1;
        drive(6'b0, 16'h0);
        @(posedge clk); #1;
        vectors++;
        if ({imem_addr, valid_id, imem_rd} !== {16'h0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_wait: addr=%h v=%b rd=%b exp 0000 0 1",
                     imem_addr, valid_id, imem_rd);
        end
        drive(F, 16'h0030);
        @(posedge clk); #1;
        vectors++;
        if ({imem_addr, imem_rd} !== {16'h0030, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_drain: addr=%h rd=%b exp 0030 0",
                     imem_addr, imem_rd);
        end
        drive(6'b0, 16'h0);
        rst = 1'b0;
        #1;
        vectors++;
        if ({imem_addr, imem_rd, valid_id} !== {16'h0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_async: addr=%h rd=%b v=%b exp 0000 1 0",
                     imem_addr, imem_rd, valid_id);
        end
        drive(D, 16'h0);
        @(posedge clk); #1;
        vectors++;
        if ({imem_addr, instr_id, valid_id} !== {16'h0, NOP, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_done_ignored: addr=%h instr=%h v=%b",
                     imem_addr, instr_id, valid_id);
        end
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        vec_t e;
        int   n;
        do_reset();
        sb.push_back(mk(D, 0, 16'h2, m(16'h0), 16'h2, 1, 1, 0));
        sb.push_back(mk(D, 0, 16'h4, m(16'h2), 16'h4, 1, 1, 0));
        sb.push_back(mk(D, 0, 16'h6, m(16'h4), 16'h6, 1, 1, 0));
        sb.push_back(mk(D, 0, 16'h8, m(16'h6), 16'h8, 1, 1, 0));
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.ctl, e.rpc);
            @(posedge clk); #1;
            vectors++;
            if ({imem_addr, instr_id, pc2_id, valid_id, imem_rd, epc} !==
                {e.addr, e.instr, e.pc2, e.valid, e.rd, e.epc}) begin
                miscompares++;
                $display("FAIL seq[%0d]: got %h %h %h %b %b %h exp %h %h %h %b %b %h",
                         n, imem_addr, instr_id, pc2_id, valid_id, imem_rd, epc,
                         e.addr, e.instr, e.pc2, e.valid, e.rd, e.epc);
            end
            n++;
        end
    endtask

    task automatic test_wait();
        vec_t e;
        int   n;
        do_reset();
        sb.push_back(mk(D, 0, 16'h2, m(16'h0), 16'h2, 1, 1, 0));
        sb.push_back(mk(D, 0, 16'h4, m(16'h2), 16'h4, 1, 1, 0));
        sb.push_back(mk(0, 0, 16'h4, NOP, 16'h4, 0, 1, 0));
        sb.push_back(mk(0, 0, 16'h4, NOP, 16'h4, 0, 1, 0));
        sb.push_back(mk(D, 0, 16'h6, m(16'h4), 16'h6, 1, 1, 0));
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.ctl, e.rpc);
            @(posedge clk); #1;
            vectors++;
            if ({imem_addr, instr_id, pc2_id, valid_id, imem_rd, epc} !==
                {e.addr, e.instr, e.pc2, e.valid, e.rd, e.epc}) begin
                miscompares++;
                $display("FAIL wait[%0d]: got %h %h %h %b %b %h exp %h %h %h %b %b %h",
                         n, imem_addr, instr_id, pc2_id, valid_id, imem_rd, epc,
                         e.addr, e.instr, e.pc2, e.valid, e.rd, e.epc);
            end
            n++;
        end
    endtask

    task automatic test_flush();
        vec_t e;
        int   n;
        do_reset();
        sb.push_back(mk(D | F, 16'h0010, 16'h10, NOP, 16'h0, 0, 1, 0));
        sb.push_back(mk(0, 0, 16'h10, NOP, 16'h0, 0, 1, 0));
        sb.push_back(mk(F, 16'h0040, 16'h40, NOP, 16'h0, 0, 0, 0));
        sb.push_back(mk(0, 0, 16'h40, NOP, 16'h0, 0, 0, 0));
        sb.push_back(mk(D, 0, 16'h40, NOP, 16'h0, 0, 1, 0));
        sb.push_back(mk(D, 0, 16'h42, m(16'h40), 16'h42, 1, 1, 0));
        sb.push_back(mk(0, 0, 16'h42, NOP, 16'h42, 0, 1, 0));
        sb.push_back(mk(F, 16'h0080, 16'h80, NOP, 16'h42, 0, 0, 0));
        sb.push_back(mk(F, 16'h0090, 16'h90, NOP, 16'h42, 0, 0, 0));
        sb.push_back(mk(D, 0, 16'h90, NOP, 16'h42, 0, 1, 0));
        sb.push_back(mk(D, 0, 16'h92, m(16'h90), 16'h92, 1, 1, 0));
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.ctl, e.rpc);
            @(posedge clk); #1;
            vectors++;
            if ({imem_addr, instr_id, pc2_id, valid_id, imem_rd, epc} !==
                {e.addr, e.instr, e.pc2, e.valid, e.rd, e.epc}) begin
                miscompares++;
                $display("FAIL flush[%0d]: got %h %h %h %b %b %h exp %h %h %h %b %b %h",
                         n, imem_addr, instr_id, pc2_id, valid_id, imem_rd, epc,
                         e.addr, e.instr, e.pc2, e.valid, e.rd, e.epc);
            end
            n++;
        end
    endtask

    task automatic test_siic_rti();
        vec_t e;
        int   n;
        do_reset();
        sb.push_back(mk(D | F, 16'h0020, 16'h20, NOP, 16'h0, 0, 1, 0));
        sb.push_back(mk(D, 0, 16'h22, m(16'h20), 16'h22, 1, 1, 0));
        sb.push_back(mk(D | I, 0, 16'h2, NOP, 16'h22, 0, 1, 16'h22));
        sb.push_back(mk(D, 0, 16'h4, m(16'h2), 16'h4, 1, 1, 16'h22));
        sb.push_back(mk(D | R, 0, 16'h22, NOP, 16'h4, 0, 1, 16'h22));
        sb.push_back(mk(D, 0, 16'h24, m(16'h22), 16'h24, 1, 1, 16'h22));
        sb.push_back(mk(D | I | R, 0, 16'h2, NOP, 16'h24, 0, 1, 16'h24));
        sb.push_back(mk(0, 0, 16'h2, NOP, 16'h24, 0, 1, 16'h24));
        sb.push_back(mk(I, 0, 16'h2, NOP, 16'h24, 0, 0, 16'h24));
        sb.push_back(mk(D, 0, 16'h2, NOP, 16'h24, 0, 1, 16'h24));
        sb.push_back(mk(D, 0, 16'h4, m(16'h2), 16'h4, 1, 1, 16'h24));
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.ctl, e.rpc);
            @(posedge clk); #1;
            vectors++;
            if ({imem_addr, instr_id, pc2_id, valid_id, imem_rd, epc} !==
                {e.addr, e.instr, e.pc2, e.valid, e.rd, e.epc}) begin
                miscompares++;
                $display("FAIL siic[%0d]: got %h %h %h %b %b %h exp %h %h %h %b %b %h",
                         n, imem_addr, instr_id, pc2_id, valid_id, imem_rd, epc,
                         e.addr, e.instr, e.pc2, e.valid, e.rd, e.epc);
            end
            n++;
        end
    endtask

    task automatic test_halt();
        vec_t e;
        int   n;
        do_reset();
        sb.push_back(mk(D | H | F, 16'h0060, 16'h60, NOP, 16'h0, 0, 1, 0));
        sb.push_back(mk(D, 0, 16'h62, m(16'h60), 16'h62, 1, 1, 0));
        sb.push_back(mk(D | H, 0, 16'h62, NOP, 16'h62, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(D | F, 16'h0070, 16'h62, NOP, 16'h62, 0, 0, 0));
        end
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.ctl, e.rpc);
            @(posedge clk); #1;
            vectors++;
            if ({imem_addr, instr_id, pc2_id, valid_id, imem_rd, epc} !==
                {e.addr, e.instr, e.pc2, e.valid, e.rd, e.epc}) begin
                miscompares++;
                $display("FAIL halt[%0d]: got %h %h %h %b %b %h exp %h %h %h %b %b %h",
                         n, imem_addr, instr_id, pc2_id, valid_id, imem_rd, epc,
                         e.addr, e.instr, e.pc2, e.valid, e.rd, e.epc);
            end
            n++;
        end
        do_reset();
        sb.push_back(mk(0, 0, 16'h0, NOP, 16'h0, 0, 1, 0));
        sb.push_back(mk(H, 0, 16'h0, NOP, 16'h0, 0, 0, 0));
        sb.push_back(mk(0, 0, 16'h0, NOP, 16'h0, 0, 0, 0));
        sb.push_back(mk(D, 0, 16'h0, NOP, 16'h0, 0, 0, 0));
        sb.push_back(mk(D, 0, 16'h0, NOP, 16'h0, 0, 0, 0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.ctl, e.rpc);
            @(posedge clk); #1;
            vectors++;
            if ({imem_addr, instr_id, pc2_id, valid_id, imem_rd, epc} !==
                {e.addr, e.instr, e.pc2, e.valid, e.rd, e.epc}) begin
                miscompares++;
                $display("FAIL halt_drain[%0d]: got %h %h %h %b %b %h exp %h %h %h %b %b %h",
                         n, imem_addr, instr_id, pc2_id, valid_id, imem_rd, epc,
                         e.addr, e.instr, e.pc2, e.valid, e.rd, e.epc);
            end
            n++;
        end
    endtask

    task automatic test_stall_wrap();
        vec_t e;
        int   n;
        do_reset();
        sb.push_back(mk(D, 0, 16'h2, m(16'h0), 16'h2, 1, 1, 0));
        sb.push_back(mk(D, 0, 16'h4, m(16'h2), 16'h4, 1, 1, 0));
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(D | S, 0, 16'h4, m(16'h2), 16'h4, 1, 1, 0));
        end
        sb.push_back(mk(S, 0, 16'h4, m(16'h2), 16'h4, 1, 1, 0));
        sb.push_back(mk(D, 0, 16'h6, m(16'h4), 16'h6, 1, 1, 0));
        sb.push_back(mk(D | S | F, 16'hFFFE, 16'hFFFE, NOP, 16'h6, 0, 1, 0));
        sb.push_back(mk(D, 0, 16'h0, m(16'hFFFE), 16'h0, 1, 1, 0));
        sb.push_back(mk(D, 0, 16'h2, m(16'h0), 16'h2, 1, 1, 0));
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.ctl, e.rpc);
            @(posedge clk); #1;
            vectors++;
            if ({imem_addr, instr_id, pc2_id, valid_id, imem_rd, epc} !==
                {e.addr, e.instr, e.pc2, e.valid, e.rd, e.epc}) begin
                miscompares++;
                $display("FAIL stall[%0d]: got %h %h %h %b %b %h exp %h %h %h %b %b %h",
                         n, imem_addr, instr_id, pc2_id, valid_id, imem_rd, epc,
                         e.addr, e.instr, e.pc2, e.valid, e.rd, e.epc);
            end
            n++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        drive(6'b0, 16'h0);
        test_reset();
        test_sequential();
        test_wait();
        test_flush();
        test_siic_rti();
        test_halt();
        test_stall_wrap();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 imem_addr  output  16  instruction address, equals PC register.
REQ-004 imem_rd  output  1  fetch request to instruction memory.
REQ-005 imem_data  input  16  instruction word, valid when imem_done=1.
REQ-006 imem_done  input  1  memory completes the outstanding request this cycle.
REQ-007 stall_id  input  1  hazard unit holds the IF/ID latch and PC.
REQ-008 flush  input  1  taken branch/jump resolved downstream.
REQ-009 redirect_pc  input  16  flush target.
REQ-010 halt_id, siic_id, rti_id  input  1 each  control from decode for the instruction in ID.
REQ-011 instr_id  output  16  IF/ID instruction, feeds decode instr.
REQ-012 pc2_id  output  16  PC+2 of instr_id.
REQ-013 valid_id  output  1  instr_id is a real instruction, not a bubble.
REQ-014 epc  output  16  exception return address.

Function
REQ-015 FSM states: RUN, WAIT, DRAIN, HALTED.
REQ-016 RUN/WAIT: imem_rd=1. DRAIN: imem_rd=0, completion discarded. HALTED: imem_rd=0.
REQ-017 Event priority, highest first: flush, halt_id, siic_id/rti_id, stall_id, normal fetch.
REQ-018 Normal, RUN, imem_done=1: IF/ID <= {imem_data, PC+2, valid=1}; PC <= PC+2, mod 2^16, wrap 0xFFFE->0x0000.
REQ-019 RUN, imem_done=0: state to WAIT; IF/ID <= bubble unless stall_id=1.
REQ-020 WAIT, imem_done=1: capture as REQ-018; state to RUN.
REQ-021 Bubble: instr_id=NOP (16'h0800), valid_id=0, pc2_id unchanged.
REQ-022 stall_id=1: PC and IF/ID hold.
REQ-022a stall_id=1 with imem_done=1 in RUN/WAIT: completion is discarded; the same PC is re-fetched next cycle.
REQ-023 flush=1, any state except HALTED: PC <= redirect_pc; IF/ID <= bubble; stall_id ignored.
REQ-024 flush in WAIT without imem_done: state to DRAIN.
REQ-025 flush in WAIT with imem_done, or flush in RUN: state to RUN.
REQ-026 DRAIN: on imem_done go to RUN, data discarded, then fetch redirect_pc.
REQ-027 A second flush during DRAIN updates PC only.
REQ-028 halt_id=1 with flush=0 and stall_id=0: IF/ID <= bubble; PC holds; state to DRAIN if a request is outstanding, otherwise HALTED.
REQ-029 DRAIN entered via halt: completion leads to HALTED, not RUN.
REQ-030 HALTED: exited only by reset; flush ignored.
REQ-031 siic_id=1, no flush/stall: epc <= pc2_id; PC <= 16'h0002; IF/ID <= bubble.
REQ-032 rti_id=1, no flush/stall: PC <= epc; IF/ID <= bubble.
REQ-033 siic_id and rti_id both 1: siic wins.
REQ-034 Outstanding request during siic/rti: discarded via DRAIN, same as REQ-024.
REQ-035 No combinational path from imem_data to imem_addr.

Reset
REQ-036 rst=0 asynchronously forces PC=0x0000, epc=0x0000, state=RUN, instr_id=NOP, pc2_id=0x0000, valid_id=0.
REQ-037 First fetch request issues from address 0x0000 in the first cycle after rst deasserts.
REQ-038 Reset mid-WAIT/DRAIN abandons the request; any imem_done in the reset-release cycle is ignored.

Structure
REQ-039 Shared package holds: NOP encoding 16'h0800, reset PC 0x0000, ISR vector 0x0002, FSM state enum.
REQ-040 The IF/ID latch (instr, pc2, valid with hold/bubble controls) is a sub-module named ifid_reg; all remaining logic is in fetch.

Verification
REQ-041 Zero-wait memory, 4 cycles after reset -> imem_addr 0,2,4,6; instr_id follows one cycle later; valid_id=1.
REQ-042 imem_done low 2 cycles at PC=0x0004 -> two bubbles (instr_id=0x0800, valid_id=0); then 0x0004 captured; PC=0x0006.
REQ-043 flush, redirect_pc=0x0040, in WAIT at PC=0x0010 -> DRAIN; late data discarded; next fetch 0x0040; no 0x0010 instruction in ID.
REQ-044 siic_id with pc2_id=0x0022 -> epc=0x0022, PC=0x0002; then rti_id -> PC=0x0022.
REQ-045 halt_id together with flush -> flush wins, fetch continues at redirect_pc; halt_id alone -> HALTED, imem_rd=0 indefinitely.
REQ-046 stall_id held 3 cycles -> PC and instr_id constant; PC at 0xFFFE -> next fetch at 0x0000.
